cpu_mc: RTL and testbench
=========================

Name: cpu_mc

Overview:
- Multi-cycle successor to the single-cycle RV32I core top.
- Fetches over a request/grant/response instruction-memory handshake, so memory may stall for any number of cycles.
- Sequences fetch, execute and write-back through an FSM. Reuses the existing decoder, regfile, alu and 2:1 immediate mux.
- Adds a retired-instruction counter, an external halt request, illegal-opcode detection and a fetch timeout fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the instret counter.
- TIMEOUT, 0, maximum cycles spent in WAIT before a fetch fault is raised; 0 disables the check.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; drive the regfile with its inverse.
- imem_req  output  1  fetch request; held until granted.
- imem_addr  output  32  fetch address (the PC); stable while imem_req is high.
- imem_gnt  input  1  memory has accepted the request.
- imem_rvalid  input  1  imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word.
- halt_req  input  1  external halt request.
- halted  output  1  core is in HALT.
- illegal  output  1  sticky; an unsupported opcode was fetched.
- fault  output  1  sticky; a fetch timeout occurred.
- instret  output  CNT_W  count of retired instructions.
- dbg_pc  output  32  current PC.

Behaviour:
- Reset (reset=0, asynchronous) puts the core in these values:
  - state=FETCH, pc=RESET_PC, ir=0
  - imem_req=0, halted=0, illegal=0, fault=0, instret=0
  - timeout counter=0
- imem_req is registered, so it rises the first edge after reset releases.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT; imem_req drops the next cycle.
  - imem_rvalid is ignored in this state.
- WAIT:
  - imem_req=0; the timeout counter increments each cycle.
  - imem_rvalid=1 -> ir<=imem_rdata -> EXEC; the counter clears.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without rvalid -> fault<=1 -> HALT.
- EXEC:
  - Decode ir; regfile reads are combinational; ALU operand b = imm when the decoder's imm_enable is set, else rs2.
  - Opcode 0010011 (OP-IMM) or 0110011 (OP) -> ALU result registered into wb_q -> WB.
  - Opcode 1110011 (ECALL/EBREAK) -> HALT; no write, no retire, pc unchanged.
  - Any other opcode -> illegal<=1 -> HALT; no write, no retire.
- WB:
  - Regfile write enable = decoder w_enable for exactly this one cycle, data wb_q; writes to x0 are discarded by the regfile.
  - pc<=pc+4, wrapping modulo 2^32.
  - instret<=instret+1, wrapping at 2^CNT_W.
  - halt_req=1 -> HALT, else -> FETCH.
- Latency: minimum 4 cycles per instruction (FETCH with gnt, WAIT with rvalid, EXEC, WB).
- halt_req is sampled only in WB. Assertion in any other state takes effect at the next WB boundary, so no in-flight fetch is abandoned.
- HALT:
  - halted=1, imem_req=0.
  - If illegal=0, fault=0 and halt_req=0 -> FETCH at the current pc.
  - illegal or fault set -> HALT is permanent until reset.
- Reset mid-transaction abandons any outstanding fetch. An rvalid arriving after reset and before the new grant is ignored.
- Simultaneous imem_gnt and imem_rvalid in FETCH: take the grant only; rvalid must arrive in a later cycle.
- dbg_pc always equals pc.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: FETCH, WAIT, EXEC, WB, HALT
  - opcode constants: OP_IMM=7'b0010011, OP=7'b0110011, SYSTEM=7'b1110011
  - INSTR_W=32
- One natural sub-module, cpu_mc_ctrl: the FSM, timeout counter and sticky flags. The datapath registers (pc, ir, wb_q, instret) and the existing-block instances stay in cpu_mc.

Test Plan:
- Fetch with zero wait (gnt in the first FETCH cycle, rvalid in the next), program addi x1,x0,5 (0x00500093), add x2,x1,x1 (0x00108133) -> x1=5, x2=10, instret=2, pc=0x8, each instruction taking 4 cycles.
- Hold gnt low 3 cycles, then rvalid 2 cycles after gnt -> imem_addr stable throughout; one retire; pc advances exactly once.
- Fetch 0x00100073 (ebreak) -> halted=1, illegal=0, pc unchanged, instret unchanged.
- Fetch 0x00002083 (lw) -> illegal=1, halted=1; raising and dropping halt_req leaves the core halted; reset clears illegal.
- TIMEOUT=8, never assert rvalid -> fault=1 after exactly 8 WAIT cycles, halted=1, imem_req=0.
- Assert halt_req during EXEC -> current instruction retires, HALT entered; drop halt_req -> fetch resumes at pc+4. Separately, pulse reset low during WAIT -> pc=RESET_PC, instret=0, and a late rvalid is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types, opcode constants and the ALU function for the multi-cycle RV32I core.
package cpu_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      WAIT  = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      HALT  = 3'd4
   } state_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   // alt selects SUB over ADD and SRA over SRL
   function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  alu_f = alt ? (a - b) : (a + b);
         3'b001:  alu_f = a << b[4:0];
         3'b010:  alu_f = {31'd0, ($signed(a) < $signed(b))};
         3'b011:  alu_f = {31'd0, (a < b)};
         3'b100:  alu_f = a ^ b;
         3'b101:  alu_f = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'b110:  alu_f = a | b;
         3'b111:  alu_f = a & b;
         default: alu_f = 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_mc_ctrl.sv
// Sequencer for the multi-cycle core: FSM, fetch timeout counter and sticky
// illegal/fault flags. imem_req and halted are registered from the next state.
module cpu_mc_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       imem_gnt,
   input  logic       imem_rvalid,
   input  logic       halt_req,
   input  logic [6:0] opcode,
   output state_t     state,
   output logic       imem_req,
   output logic       halted,
   output logic       illegal,
   output logic       fault
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   state_t      state_r;
   state_t      next_s;
   logic        imem_req_r;
   logic        halted_r;
   logic        illegal_r;
   logic        fault_r;
   logic        illegal_set_s;
   logic        fault_set_s;
   logic [31:0] to_cnt_r;

   // Next-state and flag-set decode
   always_comb begin
      next_s        = state_r;
      illegal_set_s = 1'b0;
      fault_set_s   = 1'b0;
      case (state_r)
         FETCH: begin
            // a grant only counts while our request is actually raised
            if (imem_req_r && imem_gnt) next_s = WAIT;
            else                        next_s = FETCH;
         end
         WAIT: begin
            if (imem_rvalid) begin
               next_s = EXEC;
            end else if ((TIMEOUT != 0) && (to_cnt_r == TO_LAST)) begin
               fault_set_s = 1'b1;
               next_s      = HALT;
            end else begin
               next_s = WAIT;
            end
         end
         EXEC: begin
            if ((opcode == OP_IMM) || (opcode == OP)) begin
               next_s = WB;
            end else if (opcode == SYSTEM) begin
               next_s = HALT;
            end else begin
               illegal_set_s = 1'b1;
               next_s        = HALT;
            end
         end
         WB: begin
            if (halt_req) next_s = HALT;
            else          next_s = FETCH;
         end
         HALT: begin
            if (!illegal_r && !fault_r && !halt_req) next_s = FETCH;
            else                                     next_s = HALT;
         end
         default: next_s = FETCH;
      endcase
   end

   // State, registered outputs, sticky flags and WAIT-cycle counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= FETCH;
         imem_req_r <= 1'b0;
         halted_r   <= 1'b0;
         illegal_r  <= 1'b0;
         fault_r    <= 1'b0;
         to_cnt_r   <= 32'd0;
      end else begin
         state_r    <= next_s;
         imem_req_r <= (next_s == FETCH);
         halted_r   <= (next_s == HALT);
         illegal_r  <= illegal_r | illegal_set_s;
         fault_r    <= fault_r | fault_set_s;
         if ((state_r == WAIT) && !imem_rvalid) to_cnt_r <= to_cnt_r + 32'd1;
         else                                   to_cnt_r <= 32'd0;
      end
   end

   assign state    = state_r;
   assign imem_req = imem_req_r;
   assign halted   = halted_r;
   assign illegal  = illegal_r;
   assign fault    = fault_r;

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I core top: datapath registers, decode, ALU, immediate mux
// and register file, sequenced by cpu_mc_ctrl.
module cpu_mc
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32,
   parameter int          TIMEOUT  = 0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               halt_req,
   output logic               halted,
   output logic               illegal,
   output logic               fault,
   output logic [CNT_W-1:0]   instret,
   output logic [31:0]        dbg_pc
);

   state_t             state_s;
   logic [31:0]        pc_r;
   logic [INSTR_W-1:0] ir_r;
   logic [31:0]        wb_q_r;
   logic [CNT_W-1:0]   instret_r;
   logic [31:0]        rf_r [0:31];
   logic               rf_rst_s;

   logic [6:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [2:0]  f3_s;
   logic [31:0] imm_s;
   logic        imm_enable_s;
   logic        w_enable_s;
   logic        alt_s;
   logic [31:0] op_b_s;
   logic [31:0] alu_s;

   cpu_mc_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .halt_req    (halt_req),
      .opcode      (opcode_s),
      .state       (state_s),
      .imem_req    (imem_req),
      .halted      (halted),
      .illegal     (illegal),
      .fault       (fault)
   );

   assign opcode_s     = ir_r[6:0];
   assign rd_s         = ir_r[11:7];
   assign f3_s         = ir_r[14:12];
   assign rs1_s        = ir_r[19:15];
   assign rs2_s        = ir_r[24:20];
   assign imm_s        = {{20{ir_r[31]}}, ir_r[31:20]};
   assign imm_enable_s = (opcode_s == OP_IMM);
   assign w_enable_s   = (opcode_s == OP_IMM) || (opcode_s == OP);
   // bit 30 is an immediate bit for OP-IMM except on the shift-right encoding
   assign alt_s        = ir_r[30] & ((opcode_s == OP) | (f3_s == 3'b101));
   assign op_b_s       = imm_enable_s ? imm_s : rf_r[rs2_s];
   assign alu_s        = alu_f(f3_s, alt_s, rf_r[rs1_s], op_b_s);

   // PC, instruction, write-back and retire-count registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r      <= RESET_PC;
         ir_r      <= {INSTR_W{1'b0}};
         wb_q_r    <= 32'd0;
         instret_r <= {CNT_W{1'b0}};
      end else begin
         if ((state_s == WAIT) && imem_rvalid) ir_r <= imem_rdata;
         if (state_s == EXEC) wb_q_r <= alu_s;
         if (state_s == WB) begin
            pc_r      <= pc_r + 32'd4;
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign rf_rst_s = ~reset;

   // Register file; x0 is never written so it reads as zero
   always_ff @(posedge clk or posedge rf_rst_s) begin
      if (rf_rst_s) begin
         for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
      end else if ((state_s == WB) && w_enable_s && (rd_s != 5'd0)) begin
         rf_r[rd_s] <= wb_q_r;
      end
   end

   assign imem_addr = pc_r;
   assign dbg_pc    = pc_r;
   assign instret   = instret_r;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc: the bench plays instruction memory
// and compares against hand-computed architectural results.
module tb_cpu_mc;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        halt_req;
   logic        halted;
   logic        illegal;
   logic        fault;
   logic [31:0] instret;
   logic [31:0] dbg_pc;

   int          checks;
   int          errors;
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;

   cpu_mc #(.RESET_PC(32'h0000_0000), .CNT_W(32), .TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .halt_req    (halt_req),
      .halted      (halted),
      .illegal     (illegal),
      .fault       (fault),
      .instret     (instret),
      .dbg_pc      (dbg_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
   endtask

   // Serve one fetch; returns at the negedge where the core sits in EXEC
   task automatic do_fetch(input logic [31:0] instr, input int gnt_dly, input int rv_dly);
      logic [31:0] addr0;
      wait_req();
      addr0 = imem_addr;
      for (int i = 0; i < gnt_dly; i++) begin
         @(negedge clk);
         chk("addr_hold", imem_addr, addr0);
         chk("req_hold", {31'd0, imem_req}, 32'd1);
      end
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      chk("req_drop", {31'd0, imem_req}, 32'd0);
      for (int i = 1; i < rv_dly; i++) begin
         @(negedge clk);
         chk("addr_wait", imem_addr, addr0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = instr;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
   endtask

   task automatic exec_one(input logic [31:0] instr, input int gnt_dly, input int rv_dly);
      do_fetch(instr, gnt_dly, rv_dly);
      @(negedge clk);
      chk("ret_not_yet", instret, exp_ret);
      @(negedge clk);
      exp_ret = exp_ret + 32'd1;
      exp_pc  = exp_pc + 32'd4;
      chk("instret", instret, exp_ret);
      chk("pc", dbg_pc, exp_pc);
      chk("next_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      halt_req    = 1'b0;
      exp_pc      = 32'd0;
      exp_ret     = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_pc", dbg_pc, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("req_rise", {31'd0, imem_req}, 32'd1);

      // addi x1,x0,5 ; add x2,x1,x1 with zero-wait memory
      exec_one(32'h0050_0093, 0, 1);
      exec_one(32'h0010_8133, 0, 1);
      chk("x1", dut.rf_r[1], 32'd5);
      chk("x2", dut.rf_r[2], 32'd10);
      chk("pc_after2", dbg_pc, 32'h0000_0008);

      // addi x3,x1,7 with gnt delayed 3 cycles and rvalid 2 after gnt
      exec_one(32'h0070_8193, 3, 2);
      chk("x3", dut.rf_r[3], 32'd12);
      // sub x4,x2,x1 ; slti x5,x4,6 ; addi x0,x0,9
      exec_one(32'h4011_0233, 0, 1);
      chk("x4", dut.rf_r[4], 32'd5);
      exec_one(32'h0062_2293, 0, 1);
      chk("x5", dut.rf_r[5], 32'd1);
      exec_one(32'h0090_0013, 0, 1);
      chk("x0", dut.rf_r[0], 32'd0);

      // halt_req raised in EXEC: instruction retires, then HALT
      do_fetch(32'h0010_0313, 0, 1);
      halt_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      exp_ret = exp_ret + 32'd1;
      exp_pc  = exp_pc + 32'd4;
      chk("hr_halted", {31'd0, halted}, 32'd1);
      chk("hr_instret", instret, exp_ret);
      chk("hr_pc", dbg_pc, exp_pc);
      chk("hr_req", {31'd0, imem_req}, 32'd0);
      chk("x6", dut.rf_r[6], 32'd1);
      halt_req = 1'b0;
      @(negedge clk);
      chk("resume_halted", {31'd0, halted}, 32'd0);
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr, exp_pc);

      // ebreak: halt, no retire, pc unchanged
      halt_req = 1'b1;
      do_fetch(32'h0010_0073, 0, 1);
      @(negedge clk);
      chk("eb_halted", {31'd0, halted}, 32'd1);
      chk("eb_illegal", {31'd0, illegal}, 32'd0);
      chk("eb_pc", dbg_pc, exp_pc);
      chk("eb_instret", instret, exp_ret);
      halt_req = 1'b0;
      @(negedge clk);
      chk("eb_resume", {31'd0, imem_req}, 32'd1);

      // lw: illegal and permanently halted
      do_fetch(32'h0000_2083, 0, 1);
      @(negedge clk);
      chk("il_illegal", {31'd0, illegal}, 32'd1);
      chk("il_halted", {31'd0, halted}, 32'd1);
      chk("il_pc", dbg_pc, exp_pc);
      chk("il_instret", instret, exp_ret);
      halt_req = 1'b1;
      repeat (2) @(negedge clk);
      halt_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("il_stuck", {31'd0, halted}, 32'd1);
      chk("il_noreq", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      #1;
      chk("il_cleared", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      reset   = 1'b1;
      exp_pc  = 32'd0;
      exp_ret = 32'd0;

      // fetch timeout: fault after exactly 8 WAIT cycles
      wait_req();
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      repeat (7) @(negedge clk);
      chk("to_not_yet", {31'd0, fault}, 32'd0);
      @(negedge clk);
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_halted", {31'd0, halted}, 32'd1);
      chk("to_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // reset during WAIT; a late rvalid must be ignored
      exec_one(32'h0050_0093, 0, 1);
      wait_req();
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_pc", dbg_pc, 32'd0);
      chk("mid_instret", instret, 32'd0);
      chk("mid_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      reset       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0030_0393;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      chk("late_req", {31'd0, imem_req}, 32'd1);
      chk("late_instret", instret, 32'd0);
      chk("late_halted", {31'd0, halted}, 32'd0);
      exp_pc  = 32'd0;
      exp_ret = 32'd0;
      exec_one(32'h0070_0393, 0, 1);
      chk("x7", dut.rf_r[7], 32'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
